// File: rtl/reg_file_banked_if.sv
// Register-file bus: write port, read ports, ISR control, specials and debug.
// Master is the pipeline/interrupt side, slave is the register file.
interface reg_file_banked_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
);
    logic                WE;
    logic [AW-1:0]       WADDR;
    logic [XLEN-1:0]     WDATA;
    logic [NRP*AW-1:0]   RADDR;
    logic [NRP*XLEN-1:0] RDATA;
    logic                ISR_ENTER;
    logic                ISR_EXIT;
    logic [XLEN-1:0]     PC_NEXT;
    logic [12:0]         RAND_INPUT;
    logic [XLEN-1:0]     NETWORK_STATUS;
    logic [AW-1:0]       DEBUG_ADDR;
    logic                DEBUG_BANK;
    logic [XLEN-1:0]     DEBUG_DATA;
    logic                BANK;
    logic                BUSY;
    logic                WR_DROP;

    modport master (
        output WE, WADDR, WDATA, RADDR,
        output ISR_ENTER, ISR_EXIT, PC_NEXT,
        output RAND_INPUT, NETWORK_STATUS,
        output DEBUG_ADDR, DEBUG_BANK,
        input  RDATA, DEBUG_DATA, BANK, BUSY, WR_DROP
    );

    modport slave (
        input  WE, WADDR, WDATA, RADDR,
        input  ISR_ENTER, ISR_EXIT, PC_NEXT,
        input  RAND_INPUT, NETWORK_STATUS,
        input  DEBUG_ADDR, DEBUG_BANK,
        output RDATA, DEBUG_DATA, BANK, BUSY, WR_DROP
    );
endinterface

// File: rtl/reg_file_banked.sv
// Banked RV32 integer register file with an ISR shadow bank,
// shared seed/status registers and a saved return PC.
module reg_file_banked #(
    parameter int XLEN          = 32,
    parameter int NREG          = 32,
    parameter int NRP           = 2,
    parameter int BYPASS        = 1,
    parameter int COPY_ON_ENTER = 1,
    parameter int RAND_REG      = 31,
    parameter int PC_REG        = 30,
    parameter int STATUS_REG    = 29
) (
    input logic              CLK,
    input logic              RESET,
    reg_file_banked_if.slave rf
);
    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {RUN0, COPY, RUN1} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] bank0 [NREG];
    logic [XLEN-1:0] bank1 [NREG];
    logic [XLEN-1:0] rand_q;
    logic [XLEN-1:0] status_q;
    logic            bank_q;
    logic            busy_q;
    logic            drop_q;

    logic            copying;
    logic            wr_ok;
    logic            skip;
    logic [XLEN-1:0] rand_val;

    assign copying  = (state == COPY);
    assign wr_ok    = rf.WE && !copying && (rf.WADDR != '0);
    assign skip     = (cnt == AW'(PC_REG)) ||
                      (cnt == AW'(RAND_REG)) ||
                      (cnt == AW'(STATUS_REG));
    assign rand_val = XLEN'({rf.RAND_INPUT[12], 8'd130,
                             rf.RAND_INPUT[11:0], 11'd0});

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= RUN0;
            cnt      <= '0;
            bank_q   <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
            rand_q   <= '0;
            status_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            rand_q   <= rand_val;
            status_q <= rf.NETWORK_STATUS;
            drop_q   <= rf.WE && copying && (rf.WADDR != '0);
            if (wr_ok) begin
                if (state == RUN1) bank1[rf.WADDR] <= rf.WDATA;
                else               bank0[rf.WADDR] <= rf.WDATA;
            end
            unique case (state)
                RUN0: if (rf.ISR_ENTER) begin
                    bank1[PC_REG] <= rf.PC_NEXT;
                    if (COPY_ON_ENTER != 0) begin
                        state  <= COPY;
                        cnt    <= AW'(1);
                        busy_q <= 1'b1;
                    end else begin
                        state  <= RUN1;
                        bank_q <= 1'b1;
                    end
                end
                COPY: begin
                    // bank0 is frozen while copying since writes are dropped
                    if (!skip) bank1[cnt] <= bank0[cnt];
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NREG - 1)) begin
                        state  <= RUN1;
                        busy_q <= 1'b0;
                        bank_q <= 1'b1;
                    end
                end
                RUN1: if (rf.ISR_EXIT) begin
                    state  <= RUN0;
                    bank_q <= 1'b0;
                end
                default: state <= RUN0;
            endcase
        end
    end

    function automatic logic [XLEN-1:0] rd(input logic b,
                                           input logic [AW-1:0] a);
        if (a == '0)                    return '0;
        else if (a == AW'(RAND_REG))    return rand_q;
        else if (a == AW'(STATUS_REG))  return status_q;
        else if (b)                     return bank1[a];
        else                            return bank0[a];
    endfunction

    logic [NRP*XLEN-1:0] rdata;

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NRP; k++) begin
            if (BYPASS != 0 && wr_ok &&
                rf.WADDR == rf.RADDR[k*AW +: AW])
                rdata[k*XLEN +: XLEN] = rf.WDATA;
            else
                rdata[k*XLEN +: XLEN] = rd(bank_q, rf.RADDR[k*AW +: AW]);
        end
    end

    assign rf.RDATA      = rdata;
    assign rf.DEBUG_DATA = rd(rf.DEBUG_BANK, rf.DEBUG_ADDR);
    assign rf.BANK       = bank_q;
    assign rf.BUSY       = busy_q;
    assign rf.WR_DROP    = drop_q;
endmodule

// File: tb/tb_reg_file_banked.sv
// Bench for reg_file_banked: directed vectors, ISR corner sequences
// and random traffic against a bank-level reference model.
module tb_reg_file_banked;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    reg_file_banked_if #(.XLEN(32), .AW(5), .NRP(2)) a ();
    reg_file_banked_if #(.XLEN(32), .AW(5), .NRP(2)) b ();

    reg_file_banked #(.COPY_ON_ENTER(1)) dut (
        .CLK(CLK), .RESET(RESET), .rf(a)
    );
    reg_file_banked #(.COPY_ON_ENTER(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .rf(b)
    );

    int ncmp = 0;
    int nbad = 0;

    // reference model: whole banks, mode 0=RUN0 1=COPY 2=RUN1
    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    logic [31:0] mrand, mstat;
    int          mode, left;
    logic        mdrop;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic bk, input logic [4:0] ad);
        if (ad == 0) return 0;
        if (ad == 31) return mrand;
        if (ad == 29) return mstat;
        return bk ? m1[ad] : m0[ad];
    endfunction

    task automatic mclear();
        for (int i = 0; i < 32; i++) begin
            m0[i] = 0;
            m1[i] = 0;
        end
        mrand = 0; mstat = 0; mode = 0; left = 0; mdrop = 0;
    endtask

    task automatic look();
        logic acc;
        logic [4:0] ra;
        logic [31:0] e;
        @(negedge CLK);
        acc = a.WE && mode != 1 && a.WADDR != 0;
        for (int k = 0; k < 2; k++) begin
            ra = a.RADDR[k*5 +: 5];
            e = (acc && a.WADDR == ra) ? a.WDATA : mread(mode == 2, ra);
            chk($sformatf("rdata%0d[x%0d]", k, ra), a.RDATA[k*32 +: 32], e);
        end
        if (!(mode == 1 && a.DEBUG_BANK))
            chk("debug", a.DEBUG_DATA, mread(a.DEBUG_BANK, a.DEBUG_ADDR));
        chk("bank", 32'(a.BANK), 32'(mode == 2));
        chk("busy", 32'(a.BUSY), 32'(mode == 1));
        chk("wr_drop", 32'(a.WR_DROP), 32'(mdrop));
    endtask

    task automatic tick();
        logic acc;
        if (RESET) begin
            mclear();
        end else begin
            acc = a.WE && mode != 1 && a.WADDR != 0;
            mdrop = a.WE && mode == 1 && a.WADDR != 0;
            if (acc) begin
                if (mode == 2) m1[a.WADDR] = a.WDATA;
                else           m0[a.WADDR] = a.WDATA;
            end
            if (mode == 0 && a.ISR_ENTER) begin
                m1[30] = a.PC_NEXT;
                mode = 1;
                left = 31;
            end else if (mode == 1) begin
                left--;
                if (left == 0) begin
                    for (int i = 1; i < 29; i++) m1[i] = m0[i];
                    mode = 2;
                end
            end else if (mode == 2 && a.ISR_EXIT) begin
                mode = 0;
            end
            mrand = {a.RAND_INPUT[12], 8'd130, a.RAND_INPUT[11:0], 11'd0};
            mstat = a.NETWORK_STATUS;
        end
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  r0, r1;
        logic [12:0] rnd;
        logic [31:0] ns;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t tbl [9];
    int   n;

    initial begin
        tbl[0] = '{1, 0, 32'd5,        0,  1, 13'h0,    32'h0,  32'h0,        32'h0};
        tbl[1] = '{0, 0, 32'd0,        0,  5, 13'h0,    32'h0,  32'h0,        32'h0};
        tbl[2] = '{1, 5, 32'hDEADBEEF, 5,  6, 13'h0,    32'h0,  32'hDEADBEEF, 32'h0};
        tbl[3] = '{0, 0, 32'd0,        5, 31, 13'h0,    32'h0,  32'hDEADBEEF, 32'h41000000};
        tbl[4] = '{0, 0, 32'd0,       31, 29, 13'h1FFF, 32'h0,  32'h41000000, 32'h0};
        tbl[5] = '{1, 29, 32'd1,      31,  1, 13'h1FFF, 32'hA5, 32'hC17FF800, 32'h0};
        tbl[6] = '{0, 0, 32'd0,       29, 31, 13'h1FFF, 32'hA5, 32'hA5,       32'hC17FF800};
        tbl[7] = '{1, 7, 32'h11,       7,  5, 13'h1FFF, 32'hA5, 32'h11,       32'hDEADBEEF};
        tbl[8] = '{0, 0, 32'd0,        7,  1, 13'h1FFF, 32'hA5, 32'h11,       32'h0};

        a.WE = 0; a.WADDR = 0; a.WDATA = 0; a.RADDR = 0;
        a.ISR_ENTER = 0; a.ISR_EXIT = 0; a.PC_NEXT = 0;
        a.RAND_INPUT = 0; a.NETWORK_STATUS = 0;
        a.DEBUG_ADDR = 0; a.DEBUG_BANK = 0;
        b.WE = 0; b.WADDR = 0; b.WDATA = 0; b.RADDR = 0;
        b.ISR_ENTER = 0; b.ISR_EXIT = 0; b.PC_NEXT = 0;
        b.RAND_INPUT = 0; b.NETWORK_STATUS = 0;
        b.DEBUG_ADDR = 0; b.DEBUG_BANK = 0;

        RESET = 1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 0;
        mclear();

        // reset state
        a.RADDR = {5'd17, 5'd1};
        a.DEBUG_ADDR = 5'd3; a.DEBUG_BANK = 1;
        look();
        chk("rst_busy", 32'(a.BUSY), 0);
        chk("rst_bank", 32'(a.BANK), 0);
        chk("rst_x1", a.RDATA[31:0], 0);
        tick();
        a.DEBUG_BANK = 0;

        // directed vectors
        for (int i = 0; i < 9; i++) begin
            a.WE = tbl[i].we; a.WADDR = tbl[i].waddr; a.WDATA = tbl[i].wdata;
            a.RADDR = {tbl[i].r1, tbl[i].r0};
            a.RAND_INPUT = tbl[i].rnd; a.NETWORK_STATUS = tbl[i].ns;
            look();
            chk($sformatf("vec%0d_r0", i), a.RDATA[31:0], tbl[i].e0);
            chk($sformatf("vec%0d_r1", i), a.RDATA[63:32], tbl[i].e1);
            tick();
        end
        a.WE = 0;

        // ISR entry with copy, then exit
        a.ISR_ENTER = 1; a.PC_NEXT = 32'h100;
        look(); tick();
        a.ISR_ENTER = 0;
        a.RADDR = {5'd30, 5'd7};
        n = 0;
        for (int i = 0; i < 40; i++) begin
            look();
            if (!a.BUSY) break;
            n++;
            tick();
        end
        chk("busy_len", n, 31);
        chk("isr_bank", 32'(a.BANK), 1);
        chk("isr_x7", a.RDATA[31:0], 32'h11);
        chk("isr_x30", a.RDATA[63:32], 32'h100);
        tick();
        a.WE = 1; a.WADDR = 7; a.WDATA = 32'h22;
        look(); tick();
        a.WE = 0;
        look();
        chk("isr_x7_new", a.RDATA[31:0], 32'h22);
        tick();
        a.ISR_EXIT = 1;
        look(); tick();
        a.ISR_EXIT = 0;
        a.DEBUG_BANK = 1; a.DEBUG_ADDR = 7;
        look();
        chk("exit_x7", a.RDATA[31:0], 32'h11);
        chk("exit_bank", 32'(a.BANK), 0);
        chk("exit_dbg_b1", a.DEBUG_DATA, 32'h22);
        tick();

        // WE and ISR_EXIT during copy, then reset at copy cycle 10
        a.ISR_ENTER = 1;
        look(); tick();
        a.ISR_ENTER = 0;
        a.WE = 1; a.WADDR = 8; a.WDATA = 32'h55;
        a.RADDR = {5'd7, 5'd8};
        look(); tick();
        a.WE = 0; a.ISR_EXIT = 1;
        look();
        chk("copy_drop", 32'(a.WR_DROP), 1);
        chk("copy_x8", a.RDATA[31:0], 0);
        tick();
        a.ISR_EXIT = 0;
        look();
        chk("copy_drop_end", 32'(a.WR_DROP), 0);
        chk("copy_exit_ign", 32'(a.BUSY), 1);
        tick();
        repeat (6) begin look(); tick(); end
        RESET = 1;
        look(); tick();
        RESET = 0;
        look();
        chk("abort_busy", 32'(a.BUSY), 0);
        chk("abort_x7", a.RDATA[63:32], 0);
        chk("abort_dbg", a.DEBUG_DATA, 0);
        tick();

        // no-copy variant
        b.WE = 1; b.WADDR = 7; b.WDATA = 32'h33;
        look(); tick();
        b.WE = 0; b.ISR_ENTER = 1; b.PC_NEXT = 32'h200;
        look();
        chk("nc_bank0", 32'(b.BANK), 0);
        tick();
        b.ISR_ENTER = 0;
        b.RADDR = {5'd30, 5'd7};
        b.DEBUG_ADDR = 7; b.DEBUG_BANK = 0;
        look();
        chk("nc_bank1", 32'(b.BANK), 1);
        chk("nc_busy", 32'(b.BUSY), 0);
        chk("nc_x7", b.RDATA[31:0], 0);
        chk("nc_x30", b.RDATA[63:32], 32'h200);
        chk("nc_dbg_b0", b.DEBUG_DATA, 32'h33);
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            RESET = ($urandom_range(0, 299) == 0);
            a.WE = $urandom_range(0, 1);
            a.WADDR = 5'($urandom_range(0, 31));
            a.WDATA = $urandom;
            a.RADDR = 10'($urandom);
            if ($urandom_range(0, 3) == 0) a.RADDR[4:0] = a.WADDR;
            a.ISR_ENTER = ($urandom_range(0, 19) == 0);
            a.ISR_EXIT = ($urandom_range(0, 9) == 0);
            a.PC_NEXT = $urandom;
            a.RAND_INPUT = 13'($urandom);
            a.NETWORK_STATUS = $urandom;
            a.DEBUG_ADDR = 5'($urandom);
            a.DEBUG_BANK = $urandom_range(0, 1);
            look();
            tick();
        end
        RESET = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
